run_sequencer: RTL and testbench
================================

Name: run_sequencer

Overview:
- Upstream controller for the 9-bit core top level.
- Generates the core's start pulse, launches NUM_RUNS back-to-back program runs, and waits for halt on each run.
- Reports, per run, the number of cycles the core spent running.
- Enforces a per-run timeout so a hung program cannot stall the bench or the board.

Parameters:
- NUM_RUNS, 3: runs per batch (1..255).
- START_CYCLES, 2: cycles core_start is held high per run (>=1).
- TIMEOUT, 4096: max run cycles before abort (1..2^CNT_W-1).
- CNT_W, 16: width of the cycle counter.

Ports:
- CLK  in  1: clock.
- init  in  1: reset.
- go  in  1: launch a batch; sampled in IDLE only.
- core_halt  in  1: halt from the core.
- core_start  out  1: start/reset to the core.
- busy  out  1: batch in progress.
- run_idx  out  8: index of the current/last run, 0-based.
- cycle_count  out  CNT_W: count latched at end of last run.
- run_valid  out  1: 1-cycle pulse when cycle_count updates.
- done  out  1: 1-cycle pulse at batch end.
- timeout_err  out  1: sticky; set on any timeout.

Behaviour:
- Interface: one clock (CLK), rising edge. Reset is synchronous, active-high (init).
- Reset (init=1 at the edge), regardless of state:
  - state=IDLE.
  - core_start=1, so the core is held in reset.
  - busy=0, run_idx=0, cycle_count=0, run_valid=0, done=0, timeout_err=0.
  - Internal counters cleared.
- IDLE:
  - core_start=0.
  - go=1 → START with run_idx=0, timeout_err cleared, busy=1 from the next cycle.
  - go=0 → stay in IDLE.
- START:
  - core_start=1 for exactly START_CYCLES consecutive cycles, then → RUN.
  - Run counter cleared to 0 on entry.
- RUN:
  - core_start=0.
  - Each cycle with core_halt=0: counter+1, saturating at 2^CNT_W-1.
  - core_halt=1 → RECORD; the halting cycle is not counted.
  - Counter==TIMEOUT with halt still low → timeout_err=1, then → RECORD.
- RECORD (1 cycle):
  - cycle_count<=counter; run_valid=1.
  - Timeout flagged in this run → DONE; remaining runs are skipped and run_idx stays at the failing run.
  - Else if run_idx==NUM_RUNS-1 → DONE.
  - Else run_idx+1 → START.
- DONE (1 cycle): done=1, busy=0 from the next cycle, → IDLE. core_start=0.
- Latency:
  - A halt first seen in cycle N of RUN gives run_valid on the following cycle with cycle_count=N-1.
  - go→first core_start high: 1 cycle.
- Simultaneous events:
  - core_halt=1 on the same cycle the counter hits TIMEOUT → halt wins, no error.
  - go while busy is ignored.
  - go held high in IDLE after done → a new batch starts (no edge detection).
- core_halt during START is ignored.
- init mid-batch aborts immediately. No done and no run_valid are produced.

Optional Feature:
- Macro: RUN_SEQ_LOG_EN.
- Defined:
  - Adds ports log_idx in 8 and log_data out CNT_W.
  - Each RECORD also writes the count into entry run_idx of a NUM_RUNS-entry array.
  - log_data is a combinational read of entry log_idx. An out-of-range log_idx returns 0.
  - Entries are cleared to 0 on init and on batch launch.
- Undefined: no array and no extra ports; only the last count is visible on cycle_count.

Test Plan:
- Reset hold: init=1 for 3 cycles, then go=0 → core_start=0, busy=0, all outputs 0, state IDLE.
- Three normal runs, NUM_RUNS=3: halt stub asserts after 10, 25, 7 run cycles → run_valid pulses with cycle_count 10, 25, 7 and run_idx 0, 1, 2. Then done for 1 cycle, timeout_err=0, and core_start high exactly 2 cycles before each run.
- Timeout, TIMEOUT=50: core_halt never asserts on run 1 → cycle_count=50, timeout_err=1, run_idx=1, done pulse, and run 2 never starts.
- Tie: halt asserts on the cycle the counter reaches TIMEOUT=50 → no error, cycle_count=50, batch continues.
- Reset mid-run: init pulsed during run 1 RUN → core_start=1 next cycle, busy=0, no done or run_valid; a following go restarts from run_idx=0.
- RUN_SEQ_LOG_EN: counts 10, 25, 7 → log_idx 0/1/2 read 10/25/7, log_idx 3 reads 0; a second go clears all entries to 0.

Source files
------------

// File: rtl/run_sequencer.sv
// Batch controller for the 9-bit core: pulses core_start, times each run until halt or timeout.
// Optional per-run count log enabled by defining RUN_SEQ_LOG_EN.
module run_sequencer #(
  parameter int NUM_RUNS     = 3,
  parameter int START_CYCLES = 2,
  parameter int TIMEOUT      = 4096,
  parameter int CNT_W        = 16
) (
  input  logic             CLK,
  input  logic             init,
  input  logic             go,
  input  logic             core_halt,
`ifdef RUN_SEQ_LOG_EN
  input  logic [7:0]       log_idx,
  output logic [CNT_W-1:0] log_data,
`endif
  output logic             core_start,
  output logic             busy,
  output logic [7:0]       run_idx,
  output logic [CNT_W-1:0] cycle_count,
  output logic             run_valid,
  output logic             done,
  output logic             timeout_err
);

  typedef enum logic [2:0] {IDLE, START, RUN, RECORD, DONE} state_t;

  localparam int               SC_W     = $clog2(START_CYCLES + 1);
  localparam logic [7:0]       LAST_RUN = 8'(NUM_RUNS - 1);
  localparam logic [CNT_W-1:0] TMO      = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t           state;
  logic [SC_W-1:0]  startCnt;
  logic [CNT_W-1:0] runCnt;

  // Outputs are registered, so each is set on the edge entering the state that shows it.
  always_ff @(posedge CLK) begin
    if (init) begin
      state       <= IDLE;
      core_start  <= 1'b1;
      busy        <= 1'b0;
      run_idx     <= '0;
      cycle_count <= '0;
      run_valid   <= 1'b0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
      startCnt    <= '0;
      runCnt      <= '0;
    end else begin
      run_valid <= 1'b0;
      done      <= 1'b0;
      unique case (state)
        IDLE: begin
          core_start <= 1'b0;
          if (go) begin
            state       <= START;
            core_start  <= 1'b1;
            busy        <= 1'b1;
            run_idx     <= '0;
            timeout_err <= 1'b0;
            startCnt    <= '0;
            runCnt      <= '0;
          end
        end
        START: begin
          if (startCnt == SC_W'(START_CYCLES - 1)) begin
            state      <= RUN;
            core_start <= 1'b0;
          end else begin
            startCnt <= startCnt + 1'b1;
          end
        end
        RUN: begin
          // Halt takes priority over a timeout landing on the same cycle.
          if (core_halt) begin
            state       <= RECORD;
            cycle_count <= runCnt;
            run_valid   <= 1'b1;
          end else if (runCnt == TMO) begin
            state       <= RECORD;
            cycle_count <= runCnt;
            run_valid   <= 1'b1;
            timeout_err <= 1'b1;
          end else if (runCnt != CNT_MAX) begin
            runCnt <= runCnt + 1'b1;
          end
        end
        RECORD: begin
          if (timeout_err || run_idx == LAST_RUN) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            state      <= START;
            run_idx    <= run_idx + 8'd1;
            core_start <= 1'b1;
            startCnt   <= '0;
            runCnt     <= '0;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef RUN_SEQ_LOG_EN
  logic [CNT_W-1:0] logMem [NUM_RUNS];
  logic             recordNow;

  assign recordNow = (state == RUN) && (core_halt || runCnt == TMO);

  always_ff @(posedge CLK) begin
    if (init || (state == IDLE && go)) begin
      for (int i = 0; i < NUM_RUNS; i++) logMem[i] <= '0;
    end else if (recordNow) begin
      for (int i = 0; i < NUM_RUNS; i++)
        if (run_idx == 8'(i)) logMem[i] <= runCnt;
    end
  end

  always_comb begin
    log_data = '0;
    for (int i = 0; i < NUM_RUNS; i++)
      if (log_idx == 8'(i)) log_data = logMem[i];
  end
`endif

endmodule

// File: tb/tb_run_sequencer.sv
// Bench for run_sequencer: halt stub driven by per-run delays, event monitor, table + random batches.
module tb_run_sequencer;
  localparam int NR = 3, SC = 2, TMO = 50, CW = 16;
  localparam int NEVER = 100000;

  logic          CLK = 1'b0;
  logic          init, go;
  logic          core_halt = 1'b0;
  logic          core_start, busy, run_valid, done, timeout_err;
  logic [7:0]    run_idx;
  logic [CW-1:0] cycle_count;
`ifdef RUN_SEQ_LOG_EN
  logic [7:0]    log_idx;
  logic [CW-1:0] log_data;
`endif

  int errors = 0, checks = 0;

  run_sequencer #(.NUM_RUNS(NR), .START_CYCLES(SC), .TIMEOUT(TMO), .CNT_W(CW)) dut (
    .CLK(CLK), .init(init), .go(go), .core_halt(core_halt),
`ifdef RUN_SEQ_LOG_EN
    .log_idx(log_idx), .log_data(log_data),
`endif
    .core_start(core_start), .busy(busy), .run_idx(run_idx), .cycle_count(cycle_count),
    .run_valid(run_valid), .done(done), .timeout_err(timeout_err)
  );

  always #5 CLK = ~CLK;

  // halt delay per run: number of low RUN cycles before halt is raised
  int dly[3];
  int obsCnt[$], obsIdx[$], obsCs[$];
  int doneCycles = 0, doneIdx = 0, doneErr = 0, doneBusy = 0;
  int csLen = 0, startsSeen = 0, curRun = 0, runCyc = 0;
  bit armed = 0, prevCs = 0;

  // Core stub and monitor share one negedge process so each owns its variables.
  always @(negedge CLK) begin
    if (!busy && !core_start) begin
      startsSeen = 0; armed = 0; core_halt = 1'b0;
    end else if (core_start) begin
      if (!prevCs) begin curRun = startsSeen; startsSeen++; end
      armed = 1; runCyc = 0; core_halt = 1'b0;
    end else if (armed) begin
      runCyc++;
      if (runCyc >= ((curRun < NR) ? dly[curRun] : NEVER) + 1) core_halt = 1'b1;
    end
    if (run_valid) begin armed = 0; core_halt = 1'b0; end
    prevCs = core_start;

    if (run_valid) begin
      obsCnt.push_back(int'(cycle_count));
      obsIdx.push_back(int'(run_idx));
    end
    if (done) begin
      doneCycles++;
      doneIdx = int'(run_idx); doneErr = int'(timeout_err); doneBusy = int'(busy);
    end
    if (core_start) csLen++;
    else if (csLen != 0) begin obsCs.push_back(csLen); csLen = 0; end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  int expN, expIdx, expErr;
  int expCnt[3];
  int bV, bD, bC;

  // Reference: each run counts its halt delay unless that exceeds TMO, which ends the batch.
  task automatic predict(input int d0, input int d1, input int d2);
    int d[3];
    d = '{d0, d1, d2};
    expN = 0; expErr = 0; expCnt = '{0, 0, 0};
    for (int i = 0; i < NR; i++) begin
      expN = i + 1;
      if (d[i] > TMO) begin expCnt[i] = TMO; expErr = 1; break; end
      expCnt[i] = d[i];
    end
    expIdx = expN - 1;
  endtask

  task automatic waitDone(input int target, output bit ok);
    ok = 0;
    for (int c = 0; c < 2000; c++) begin
      @(posedge CLK);
      if (doneCycles >= target) begin ok = 1; break; end
    end
  endtask

  task automatic launch(input bit hold);
    @(posedge CLK); #1;
    bV = obsCnt.size(); bD = doneCycles; bC = obsCs.size();
    @(negedge CLK);
    chk("idle_core_start", int'(core_start), 0);
    go = 1'b1;
    @(negedge CLK);
    chk("go_to_core_start", int'(core_start), 1);
    chk("go_to_busy", int'(busy), 1);
`ifdef RUN_SEQ_LOG_EN
    for (int i = 0; i <= NR; i++) begin
      log_idx = 8'(i); #1;
      chk($sformatf("log_clear[%0d]", i), int'(log_data), 0);
    end
`endif
    if (!hold) go = 1'b0;
  endtask

  task automatic verify();
    int n;
    n = obsCnt.size() - bV;
    chk("n_run_valid", n, expN);
    for (int i = 0; i < expN && i < n; i++) begin
      chk($sformatf("cycle_count[%0d]", i), obsCnt[bV + i], expCnt[i]);
      chk($sformatf("run_idx[%0d]", i), obsIdx[bV + i], i);
    end
    chk("n_done", doneCycles - bD, 1);
    chk("done_run_idx", doneIdx, expIdx);
    chk("done_timeout_err", doneErr, expErr);
    chk("done_busy", doneBusy, 1);
    chk("n_starts", obsCs.size() - bC, expN);
    for (int i = 0; i < expN && bC + i < obsCs.size(); i++)
      chk($sformatf("start_len[%0d]", i), obsCs[bC + i], SC);
`ifdef RUN_SEQ_LOG_EN
    for (int i = 0; i <= NR; i++) begin
      log_idx = 8'(i); #1;
      chk($sformatf("log[%0d]", i), int'(log_data), (i < expN) ? expCnt[i] : 0);
    end
`endif
  endtask

  task automatic runBatch(input int d0, input int d1, input int d2, input bit hold);
    bit ok;
    dly = '{d0, d1, d2};
    launch(hold);
    waitDone(bD + 1, ok);
    chk("done_seen", int'(ok), 1);
    if (!ok) begin go = 1'b0; return; end
    verify();
    @(negedge CLK);
    chk("busy_after_done", int'(busy), 0);
    chk("done_one_cycle", int'(done), 0);
    if (hold) begin
      @(negedge CLK);
      chk("held_go_restart_cs", int'(core_start), 1);
      chk("held_go_restart_busy", int'(busy), 1);
      go = 1'b0;
      waitDone(bD + 2, ok);
      chk("held_go_done", int'(ok), 1);
    end
  endtask

  typedef struct {
    int d0, d1, d2;
    int n, c0, c1, c2, idx, err;
  } vec_t;

  initial begin
    vec_t tbl[5];
    int nv, nd;
    bit ok;
    tbl[0] = '{10, 25, 7,     3, 10, 25,  7, 2, 0};
    tbl[1] = '{10, NEVER, 5,  2, 10, 50,  0, 1, 1};
    tbl[2] = '{50, 50, 50,    3, 50, 50, 50, 2, 0};
    tbl[3] = '{51, 3, 3,      1, 50,  0,  0, 0, 1};
    tbl[4] = '{0, 1, 49,      3,  0,  1, 49, 2, 0};

    init = 1'b1; go = 1'b0;
`ifdef RUN_SEQ_LOG_EN
    log_idx = '0;
`endif
    repeat (3) @(negedge CLK);
    chk("rst_core_start", int'(core_start), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_run_idx", int'(run_idx), 0);
    chk("rst_cycle_count", int'(cycle_count), 0);
    chk("rst_run_valid", int'(run_valid), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_timeout_err", int'(timeout_err), 0);
    init = 1'b0;
    @(negedge CLK);
    chk("idle_core_start_low", int'(core_start), 0);
    chk("idle_busy", int'(busy), 0);
    repeat (2) @(negedge CLK);

    for (int v = 0; v < 5; v++) begin
      expN = tbl[v].n; expIdx = tbl[v].idx; expErr = tbl[v].err;
      expCnt = '{tbl[v].c0, tbl[v].c1, tbl[v].c2};
      runBatch(tbl[v].d0, tbl[v].d1, tbl[v].d2, 1'b0);
    end

    // go held high for a whole batch: ignored while busy, relaunches from IDLE
    expN = 3; expIdx = 2; expErr = 0; expCnt = '{10, 25, 7};
    runBatch(10, 25, 7, 1'b1);

    // init in the middle of run 1
    dly = '{5, NEVER, 5};
    launch(1'b0);
    ok = 0;
    for (int c = 0; c < 500; c++) begin
      @(posedge CLK);
      if (obsCnt.size() >= bV + 1) begin ok = 1; break; end
    end
    chk("midrun_first_valid", int'(ok), 1);
    repeat (8) @(posedge CLK);
    @(negedge CLK);
    chk("midrun_busy", int'(busy), 1);
    init = 1'b1;
    nv = obsCnt.size(); nd = doneCycles;
    @(negedge CLK);
    chk("midrun_init_core_start", int'(core_start), 1);
    chk("midrun_init_busy", int'(busy), 0);
    chk("midrun_init_run_idx", int'(run_idx), 0);
    chk("midrun_init_run_valid", int'(run_valid), 0);
    chk("midrun_init_done", int'(done), 0);
    init = 1'b0;
`ifdef RUN_SEQ_LOG_EN
    log_idx = 8'd0; #1;
    chk("midrun_init_log_clear", int'(log_data), 0);
`endif
    repeat (20) @(posedge CLK);
    chk("midrun_no_run_valid", obsCnt.size(), nv);
    chk("midrun_no_done", doneCycles, nd);
    expN = 3; expIdx = 2; expErr = 0; expCnt = '{10, 25, 7};
    runBatch(10, 25, 7, 1'b0);

    for (int r = 0; r < 8; r++) begin
      int d[3];
      for (int i = 0; i < 3; i++)
        d[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(45, 55)) : int'($urandom_range(0, 40));
      predict(d[0], d[1], d[2]);
      runBatch(d[0], d[1], d[2], 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
